// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder: FSM state encoding,
// counter width and the legal WIDTH range.
package serial_adder_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
    localparam int CNT_W     = $clog2(WIDTH_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
// ovf exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin,
                    input  ready, busy, done, sum, cout, ovf);
    modport slave  (input  start, a, b, cin,
                    output ready, busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin,
                    input  ready, busy, done, sum, cout);
    modport slave  (input  start, a, b, cin,
                    output ready, busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_fa_bit.sv
// One-bit full adder built from gate primitives; purely combinational,
// zero latency, no flow control.
module serial_fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic axb;
    logic gen;
    logic prop;

    xor u_x0 (axb,  a,   b);
    xor u_x1 (s,    axb, ci);
    and u_a0 (gen,  a,   b);
    and u_a1 (prop, axb, ci);
    or  u_o0 (co,   gen, prop);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first through one full-adder cell; done pulses WIDTH+1 cycles after accept.
// start is taken only while ready (IDLE/DONE) and ignored in RUN; SERIAL_ADDER_OVF_EN adds signed ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_chk
        $error("serial_adder: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-2:0]   sum_sh;
    logic               carry_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic               cmsb_q;
`endif

    logic               fa_s;
    logic               fa_co;
    logic               rdy;
    logic               accept;
    logic               last;
    logic [WIDTH-1:0]   sum_cat;

    serial_fa_bit u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign rdy     = (state_q == IDLE) || (state_q == DONE);
    assign accept  = rdy && bus.start;
    assign last    = (state_q == RUN) && (cnt_q == LAST_CNT);
    // Only WIDTH-1 bits are stored; the final cell sum completes the word on capture.
    assign sum_cat = {fa_s, sum_sh};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state_q)
            IDLE: bus.ready = 1'b1;
            RUN:  bus.busy  = 1'b1;
            DONE: begin
                bus.ready = 1'b1;
                bus.done  = 1'b1;
            end
            default: bus.ready = 1'b0;
        endcase
        bus.sum  = sum_q;
        bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        bus.ovf  = cmsb_q ^ cout_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            cmsb_q  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                a_sh    <= bus.a;
                b_sh    <= bus.b;
                carry_q <= bus.cin;
                cnt_q   <= '0;
                sum_sh  <= '0;
            end else if (state_q == RUN) begin
                a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
                b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                sum_sh  <= sum_cat[WIDTH-1:1];
                carry_q <= fa_co;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
            if (last) begin
                sum_q  <= sum_cat;
                cout_q <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                // carry_q here is the carry into the MSB position
                cmsb_q <= carry_q;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder: driver pushes expected results, a negedge monitor
// pops and checks them whenever done is seen.
module tb_serial_adder;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   total     = 0;
    int   bad       = 0;
    int   cyc       = 0;
    int   busy_cnt  = 0;
    int   last_done = 0;
    int   gap       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: latency counts cycles from the accepting cycle through the done cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (bus.busy) busy_cnt++;
                if (bus.done) begin
                    gap       = cyc - last_done;
                    last_done = cyc;
                    chk("done_ready", 32'(bus.ready), 32'd1);
                    chk("done_busy", 32'(bus.busy), 32'd0);
                    chk("busy_len", busy_cnt, W);
                    busy_cnt = 0;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done with sum %0h, want no done", bus.sum);
                    end else begin
                        e = sb.pop_front();
                        chk("sum", 32'(bus.sum), 32'(e.sum));
                        chk("cout", 32'(bus.cout), 32'(e.cout));
                        chk("latency", cyc - e.acc + 1, W + 1);
`ifdef SERIAL_ADDER_OVF_EN
                        chk("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: ready=%0b want 1", bus.ready);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] es, input logic ec, input logic eo);
        exp_t e;
        e.sum  = es;
        e.cout = ec;
        e.ovf  = eo;
        e.acc  = cyc;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        wait_ready();
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        @(posedge clk);
        #1;
        push_exp(es, ec, eo);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        #12;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Basic vectors: a, b, cin, expected sum, cout, ovf
        issue(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        drain();
        repeat (3) @(negedge clk);
        chk("hold_sum", 32'(bus.sum), 32'h10);
        chk("idle_ready", 32'(bus.ready), 32'd1);

        issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        issue(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        drain();

        // start pulsed during RUN must be ignored
        issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.cin   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        // start held high: second request is taken straight from DONE
        wait_ready();
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h02;
        bus.cin   = 1'b0;
        @(posedge clk);
        #1;
        push_exp(8'h03, 1'b0, 1'b0);
        @(negedge clk);
        bus.a = 8'h03;
        bus.b = 8'h04;
        wait_ready();
        @(posedge clk);
        #1;
        push_exp(8'h07, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        chk("b2b_gap", gap, W + 1);

        // reset in the middle of an operation discards it
        wait_ready();
        bus.start = 1'b1;
        bus.a     = 8'hA5;
        bus.b     = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_sum", 32'(bus.sum), 32'd0);
        chk("abort_cout", 32'(bus.cout), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_ready", 32'(bus.ready), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
        chk("abort_ovf", 32'(bus.ovf), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0);
        drain();
        repeat (12) @(negedge clk);
        chk("final_busy", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
